// File: rtl/key_bounce_gen_if.sv
// Handshake bundle for key_bounce_gen: press request in, emulated key and status out.
// The abort signal exists only when KEY_BOUNCE_ABORT_EN is defined.
interface key_bounce_gen_if;
    logic       press_req;
    logic       key;
    logic       busy;
    logic       done;
    logic [7:0] bounce_edges;
`ifdef KEY_BOUNCE_ABORT_EN
    logic       abort;
`endif

    modport master (
`ifdef KEY_BOUNCE_ABORT_EN
        output abort,
`endif
        output press_req,
        input  key, busy, done, bounce_edges
    );

    modport slave (
`ifdef KEY_BOUNCE_ABORT_EN
        input  abort,
`endif
        input  press_req,
        output key, busy, done, bounce_edges
    );
endinterface

// File: rtl/key_bounce_gen.sv
// Emulates a bouncing active-low mechanical key: press bounce, hold, release bounce.
// Optional KEY_BOUNCE_ABORT_EN adds an abort input that returns the block to idle.
module key_bounce_gen #(
    parameter int unsigned BOUNCE_MAX = 20,
    parameter int unsigned HOLD_CNT   = 50,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    key_bounce_gen_if.slave kb
);
    typedef enum logic [1:0] {IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE} state_t;

    localparam logic [7:0]  BOUNCE_LAST = 8'(BOUNCE_MAX - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CNT - 1);
    localparam logic [15:0] SEED_LOAD   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    state_t      state, state_nxt;
    logic [7:0]  bounce_cnt, bounce_cnt_nxt;
    logic [15:0] hold_cnt, hold_cnt_nxt;
    logic [15:0] lfsr, lfsr_nxt;
    logic        key_q, key_prev, key_nxt;
    logic        done_q, done_nxt;
    logic        busy;
    logic [7:0]  edge_cnt;
    logic        abort_req;

`ifdef KEY_BOUNCE_ABORT_EN
    assign abort_req = kb.abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:           if (kb.press_req)              state_nxt = PRESS_BOUNCE;
            PRESS_BOUNCE:   if (bounce_cnt == BOUNCE_LAST) state_nxt = HOLD;
            HOLD:           if (hold_cnt == HOLD_LAST)     state_nxt = RELEASE_BOUNCE;
            RELEASE_BOUNCE: if (bounce_cnt == BOUNCE_LAST) state_nxt = IDLE;
        endcase
        if (abort_req && state != IDLE) state_nxt = IDLE;
    end

    // Counters restart on every state change so each phase counts from zero.
    always_comb begin
        lfsr_nxt       = lfsr;
        bounce_cnt_nxt = '0;
        hold_cnt_nxt   = '0;
        if (state == PRESS_BOUNCE || state == RELEASE_BOUNCE)
            lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
        if (state_nxt == state) begin
            if (state == PRESS_BOUNCE || state == RELEASE_BOUNCE)
                bounce_cnt_nxt = bounce_cnt + 8'd1;
            if (state == HOLD)
                hold_cnt_nxt = hold_cnt + 16'd1;
        end
    end

    // Key is registered from the upcoming state so it lines up with that state's cycle.
    always_comb begin
        busy     = (state != IDLE);
        done_nxt = (state == RELEASE_BOUNCE) && (state_nxt == IDLE) && !abort_req;
        key_nxt  = 1'b1;
        unique case (state_nxt)
            IDLE:           key_nxt = 1'b1;
            PRESS_BOUNCE:   key_nxt = (bounce_cnt_nxt == BOUNCE_LAST) ? 1'b0 : lfsr_nxt[0];
            HOLD:           key_nxt = 1'b0;
            RELEASE_BOUNCE: key_nxt = (bounce_cnt_nxt == BOUNCE_LAST) ? 1'b1 : lfsr_nxt[0];
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_q      <= 1'b1;
            key_prev   <= 1'b1;
            done_q     <= 1'b0;
            lfsr       <= SEED_LOAD;
            bounce_cnt <= '0;
            hold_cnt   <= '0;
            edge_cnt   <= '0;
        end else begin
            key_q      <= key_nxt;
            key_prev   <= key_q;
            done_q     <= done_nxt;
            lfsr       <= lfsr_nxt;
            bounce_cnt <= bounce_cnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            // A transition is counted one edge after it appears on key.
            if (state == IDLE && state_nxt == PRESS_BOUNCE)
                edge_cnt <= '0;
            else if (state != IDLE && key_q != key_prev && edge_cnt != 8'hFF)
                edge_cnt <= edge_cnt + 8'd1;
        end
    end

    assign kb.key          = key_q;
    assign kb.busy         = busy;
    assign kb.done         = done_q;
    assign kb.bounce_edges = edge_cnt;
endmodule

// File: tb/tb_key_bounce_gen.sv
// Scoreboard bench for key_bounce_gen: a reference LFSR model predicts each sequence.
module tb_key_bounce_gen;
    localparam int unsigned BOUNCE_MAX = 20;
    localparam int unsigned HOLD_CNT   = 50;
    localparam logic [15:0] SEED       = 16'hACE1;
    localparam int unsigned SEQ_LEN    = 2 * BOUNCE_MAX + HOLD_CNT;
    localparam int unsigned PERIOD     = SEQ_LEN + 1;

    typedef struct {
        logic        key;
        logic        busy;
        logic        done;
        logic        first;
        logic        chain;
        int unsigned ref_cyc;
        int unsigned idx;
        logic [15:0] lfsr_after;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic press_req = 1'b0;
    bit   mon_en = 1'b0;

    key_bounce_gen_if kb ();
    key_bounce_gen_if k0 ();
    assign kb.press_req = press_req;
    assign k0.press_req = press_req;
`ifdef KEY_BOUNCE_ABORT_EN
    logic abort = 1'b0;
    assign kb.abort = abort;
    assign k0.abort = 1'b0;
`endif

    key_bounce_gen #(.BOUNCE_MAX(BOUNCE_MAX), .HOLD_CNT(HOLD_CNT), .LFSR_SEED(SEED))
        u_dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .kb(kb));
    key_bounce_gen #(.BOUNCE_MAX(BOUNCE_MAX), .HOLD_CNT(HOLD_CNT), .LFSR_SEED(16'h0000))
        u_seed0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .kb(k0));

    always #5 sys_clk = ~sys_clk;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    exp_t exp_q[$];
    exp_t exp0_q[$];
    logic [15:0] m_lfsr = SEED;
    logic [15:0] m0_lfsr = 16'h0001;
    logic [15:0] last_lfsr = SEED;
    int unsigned cyc = 0;
    int unsigned toggles = 0;
    int unsigned done_cnt = 0;
    int unsigned edges_exp = 0;
    bit edges_chk = 1'b0;
    bit rst_seen = 1'b0;
    bit have_first = 1'b0;
    logic prev_key = 1'b1;
    logic [SEQ_LEN-1:0] cap_cur = '0;
    logic [SEQ_LEN-1:0] cap_first = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic push_seq(input bit alt, input int unsigned at_cyc, input bit chain);
        exp_t e;
        logic [15:0] l;
        l = alt ? m0_lfsr : m_lfsr;
        for (int unsigned i = 0; i < SEQ_LEN; i++) begin
            e.busy = 1'b1; e.done = 1'b0; e.first = (i == 0); e.chain = 1'b0;
            e.ref_cyc = 0; e.idx = i;
            if (i < BOUNCE_MAX) begin
                e.key = (i == BOUNCE_MAX - 1) ? 1'b0 : l[0];
                l = lfsr_step(l);
            end else if (i < BOUNCE_MAX + HOLD_CNT) begin
                e.key = 1'b0;
            end else begin
                e.key = (i == SEQ_LEN - 1) ? 1'b1 : l[0];
                l = lfsr_step(l);
            end
            e.lfsr_after = l;
            if (alt) exp0_q.push_back(e); else exp_q.push_back(e);
        end
        e.key = 1'b1; e.busy = 1'b0; e.done = 1'b1; e.first = 1'b0; e.chain = chain;
        e.ref_cyc = at_cyc; e.idx = 0; e.lfsr_after = l;
        if (alt) begin exp0_q.push_back(e); m0_lfsr = l; end
        else     begin exp_q.push_back(e);  m_lfsr = l;  end
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        exp_t e0;
        bit chain;
        if (mon_en) begin
            cyc++;
            chain = 1'b0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("key", kb.key, e.key);
                check("busy", kb.busy, e.busy);
                check("done", kb.done, e.done);
                if (e.busy) begin
                    cap_cur[e.idx] = kb.key;
                    if (e.first) toggles = 0;
                    if (kb.key !== prev_key) toggles++;
                end
                last_lfsr = e.lfsr_after;
                if (e.done) begin
                    chain = 1'b1;
                    done_cnt++;
                    check("edges", kb.bounce_edges, toggles);
                    check("edges_min", toggles >= 2, 1);
                    if (e.chain) check("period", cyc - e.ref_cyc, PERIOD);
                    if (rst_seen) begin
                        if (!have_first) begin
                            cap_first = cap_cur;
                            have_first = 1'b1;
                        end else begin
                            check("replay", cap_cur, cap_first);
                        end
                        rst_seen = 1'b0;
                    end
                end
            end else begin
                check("idle", {kb.key, kb.busy, kb.done}, 3'b100);
                if (edges_chk) begin
                    check("abort_edges", kb.bounce_edges, edges_exp);
                    edges_chk = 1'b0;
                end
            end
            prev_key = kb.key;

            if (exp0_q.size() > 0) begin
                e0 = exp0_q.pop_front();
                check("seed0_key", k0.key, e0.key);
                check("seed0_busy", k0.busy, e0.busy);
            end

            if (sys_rst) begin
                exp_q.delete();
                exp0_q.delete();
                m_lfsr = SEED;
                m0_lfsr = 16'h0001;
                rst_seen = 1'b1;
                edges_chk = 1'b0;
            end
`ifdef KEY_BOUNCE_ABORT_EN
            if (!sys_rst && abort && kb.busy) begin
                exp_q.delete();
                m_lfsr = last_lfsr;
                edges_chk = 1'b1;
                edges_exp = toggles;
            end
`endif
            if (!sys_rst && !kb.busy && press_req) push_seq(1'b0, cyc, chain);
            if (!sys_rst && !k0.busy && press_req) push_seq(1'b1, cyc, 1'b0);
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        tick(1);
        mon_en = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        check("rst_edges", kb.bounce_edges, 0);
        tick(5);

        press_req = 1'b1; tick(1); press_req = 1'b0;
        tick(100);

        press_req = 1'b1; tick(300); press_req = 1'b0;
        tick(100);

        // Presses while busy must not disturb timing.
        press_req = 1'b1; tick(1); press_req = 1'b0;
        tick(9);  press_req = 1'b1; tick(1); press_req = 1'b0;
        tick(30); press_req = 1'b1; tick(1); press_req = 1'b0;
        tick(40); press_req = 1'b1; tick(1); press_req = 1'b0;
        tick(20);

        // Reset during HOLD cycle 10 (busy cycle 30).
        press_req = 1'b1; tick(1); press_req = 1'b0;
        tick(29);
        sys_rst = 1'b1; tick(1); sys_rst = 1'b0;
        tick(5);
        press_req = 1'b1; tick(1); press_req = 1'b0;
        tick(100);

`ifdef KEY_BOUNCE_ABORT_EN
        // Abort during RELEASE_BOUNCE cycle 5 (busy cycle 75).
        press_req = 1'b1; tick(1); press_req = 1'b0;
        tick(74);
        abort = 1'b1; tick(1); abort = 1'b0;
        tick(100);
`endif

        check("done_count", done_cnt, 7);
        check("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
